// File: rtl/td4_pkg.sv
// Shared widths, opcodes and state encoding for the TD4 execution controller.
package td4_pkg;

  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned IMM_W   = 4;
  localparam int unsigned STATE_W = 3;

  localparam logic [OP_W-1:0] JMP_OPCODE = OP_W'(4'hF);

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_HALT  = 3'd4,
    ST_STEP  = 3'd5
  } state_e;

endpackage

// File: rtl/td4_load_ptr.sv
// Program-load write pointer: clears, advances per accepted word, wraps at memory depth.
module td4_load_ptr
  import td4_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] wptr,
  output logic              last_c
);

  logic [ADDR_W-1:0] wptr_d, wptr_q;

  always_comb begin
    wptr_d = wptr_q;
    if (clr) begin
      wptr_d = '0;
    end else if (inc) begin
      wptr_d = wptr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
    end
  end

  assign wptr   = wptr_q;
  assign last_c = (wptr_q == {ADDR_W{1'b1}});

endmodule

// File: rtl/td4_exec_ctrl.sv
// TD4 sequencer: program load, CPU run/step/halt gating, jump-to-self halt detection.
// Optional breakpoint support is enabled by defining TD4_BREAKPOINT_EN.
module td4_exec_ctrl
  import td4_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_req,
  input  logic               run_req,
  input  logic               step_req,
  input  logic               stop_req,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [OP_W-1:0]    ld_opcode,
  input  logic [IMM_W-1:0]   ld_imm,
  input  logic [ADDR_W-1:0]  pc,
  input  logic [OP_W-1:0]    fetch_opcode,
  input  logic [IMM_W-1:0]   fetch_imm,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_write,
  output logic [OP_W-1:0]    mem_opcode,
  output logic [IMM_W-1:0]   mem_imm,
  output logic               cpu_en,
  output logic               cpu_restart,
  input  logic [ADDR_W-1:0]  bp_addr,
  input  logic               bp_en,
  output logic [STATE_W-1:0] state_o,
  output logic               load_done,
  output logic               halted
);

  state_e            state_d, state_q;
  logic              load_done_d, load_done_q;
  logic              bp_skip_d;
  logic              ptr_clr;
  logic              ptr_last_c;
  logic              halt_idiom_c;
  logic              bp_hit_c;
  logic [ADDR_W-1:0] wptr;

  td4_load_ptr u_load_ptr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (ptr_clr),
    .inc    (mem_write),
    .wptr   (wptr),
    .last_c (ptr_last_c)
  );

  assign halt_idiom_c = (fetch_opcode == JMP_OPCODE) && (ADDR_W'(fetch_imm) == pc);

`ifdef TD4_BREAKPOINT_EN
  // Skip flag lets a resumed run execute the breakpointed instruction once.
  logic bp_skip_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bp_skip_q <= 1'b0;
    end else begin
      bp_skip_q <= bp_skip_d;
    end
  end

  assign bp_hit_c = bp_en && (pc == bp_addr) && !bp_skip_q;
`else
  logic unused_bp;
  assign unused_bp = ^{bp_en, bp_addr, bp_skip_d};
  assign bp_hit_c  = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    load_done_d = load_done_q;
    bp_skip_d   = 1'b0;
    ptr_clr     = 1'b0;
    ld_ready    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = pc;
    mem_opcode  = '0;
    mem_imm     = '0;
    cpu_en      = 1'b0;
    cpu_restart = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!stop_req) begin
          if (load_req) begin
            state_d     = ST_LOAD;
            load_done_d = 1'b0;
            ptr_clr     = 1'b1;
          end else if (run_req) begin
            state_d = ST_START;
          end
        end
      end
      ST_LOAD: begin
        mem_addr   = wptr;
        mem_opcode = ld_opcode;
        mem_imm    = ld_imm;
        // An abort withdraws ready so the loader never sees a dropped word as taken.
        if (stop_req) begin
          state_d = ST_IDLE;
          ptr_clr = 1'b1;
        end else begin
          ld_ready  = 1'b1;
          mem_write = ld_valid;
          if (ld_valid && ptr_last_c) begin
            state_d     = ST_IDLE;
            load_done_d = 1'b1;
          end
        end
      end
      ST_START: begin
        cpu_restart = 1'b1;
        state_d     = ST_RUN;
      end
      ST_RUN: begin
        cpu_en = 1'b1;
        if (bp_hit_c) begin
          cpu_en  = 1'b0;
          state_d = ST_HALT;
        end else if (stop_req || halt_idiom_c) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        if (!stop_req) begin
          if (load_req) begin
            state_d     = ST_LOAD;
            load_done_d = 1'b0;
            ptr_clr     = 1'b1;
          end else if (run_req) begin
            state_d   = ST_RUN;
            bp_skip_d = 1'b1;
          end else if (step_req) begin
            state_d = ST_STEP;
          end
        end
      end
      ST_STEP: begin
        cpu_en  = 1'b1;
        state_d = ST_HALT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_done_q <= load_done_d;
    end
  end

  assign state_o   = state_q;
  assign load_done = load_done_q;
  assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_td4_exec_ctrl.sv
// Self-checking bench for td4_exec_ctrl with a memory/CPU environment and a program-trace model.
module tb_td4_exec_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_req, run_req, step_req, stop_req;
  logic       ld_valid, ld_ready;
  logic [3:0] ld_opcode, ld_imm;
  logic [3:0] pc_r;
  logic [3:0] fetch_opcode, fetch_imm;
  logic [3:0] mem_addr;
  logic       mem_write;
  logic [3:0] mem_opcode, mem_imm;
  logic       cpu_en, cpu_restart;
  logic [3:0] bp_addr;
  logic       bp_en;
  logic [2:0] state_o;
  logic       load_done, halted;

`ifdef TD4_BREAKPOINT_EN
  localparam bit BP_ON = 1'b1;
`else
  localparam bit BP_ON = 1'b0;
`endif

  td4_exec_ctrl dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .run_req(run_req),
    .step_req(step_req), .stop_req(stop_req), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_opcode(ld_opcode), .ld_imm(ld_imm), .pc(pc_r), .fetch_opcode(fetch_opcode),
    .fetch_imm(fetch_imm), .mem_addr(mem_addr), .mem_write(mem_write),
    .mem_opcode(mem_opcode), .mem_imm(mem_imm), .cpu_en(cpu_en),
    .cpu_restart(cpu_restart), .bp_addr(bp_addr), .bp_en(bp_en), .state_o(state_o),
    .load_done(load_done), .halted(halted)
  );

  always #5 clk = ~clk;

  // Environment: 16-word program memory and a minimal CPU that only tracks the PC.
  logic [7:0] mem_img [16];
  assign fetch_opcode = mem_img[mem_addr][7:4];
  assign fetch_imm    = mem_img[mem_addr][3:0];

  always @(posedge clk) begin
    if (mem_write) mem_img[mem_addr] <= {mem_opcode, mem_imm};
  end

  always @(posedge clk) begin
    if (!rst_n)           pc_r <= 4'd9;
    else if (cpu_restart) pc_r <= 4'd0;
    else if (cpu_en)      pc_r <= (fetch_opcode == 4'hF) ? fetch_imm : pc_r + 4'd1;
  end

  int n_chk = 0;
  int n_fail = 0;
  int en_cnt = 0;
  int rst_cnt = 0;
  logic [11:0] wr_log [$];
  logic [3:0]  p_op [16];
  logic [3:0]  p_imm [16];
  logic [2:0]  s_state;
  logic        s_en, s_rst, s_halted, s_ldr, s_done, s_wr;
  logic [3:0]  s_addr, s_pc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs are driven at the falling edge; outputs are sampled 3ns later, before the rising edge.
  task automatic cyc();
    #3;
    s_state = state_o; s_en = cpu_en; s_rst = cpu_restart; s_halted = halted;
    s_ldr = ld_ready; s_done = load_done; s_wr = mem_write; s_addr = mem_addr; s_pc = pc_r;
    if (mem_write) wr_log.push_back({mem_addr, mem_opcode, mem_imm});
    if (cpu_en) en_cnt++;
    if (cpu_restart) rst_cnt++;
    @(negedge clk);
  endtask

  // Walks the program from address 0; returns instructions executed up to and including the self-jump.
  task automatic trace(output int n, output int hpc);
    logic [3:0] q;
    q = 4'd0;
    n = 0;
    for (int k = 0; k < 64; k++) begin
      n++;
      if (p_op[q] == 4'hF && p_imm[q] == q) break;
      q = (p_op[q] == 4'hF) ? p_imm[q] : q + 4'd1;
    end
    hpc = int'(q);
  endtask

  task automatic load_prog(input bit gap, input int stop_at);
    int idx;
    bit stopped;
    int exp_n;
    idx = 0;
    stopped = 1'b0;
    wr_log.delete();
    load_req = 1'b1; cyc(); load_req = 1'b0;
    for (int k = 0; k < 200 && idx < 16 && !stopped; k++) begin
      ld_valid  = gap ? ($urandom_range(0, 2) != 0) : 1'b1;
      ld_opcode = p_op[idx];
      ld_imm    = p_imm[idx];
      stop_req  = (idx == stop_at);
      cyc();
      if (stop_req) begin
        chk("stop_no_write", s_wr, 0);
        stopped = 1'b1;
      end else if (ld_valid && s_ldr) begin
        idx++;
      end
    end
    ld_valid = 1'b0; stop_req = 1'b0;
    cyc();
    exp_n = stopped ? stop_at : 16;
    chk("wr_count", wr_log.size(), exp_n);
    for (int i = 0; i < wr_log.size() && i < exp_n; i++)
      chk("wr_word", wr_log[i], {4'(i), p_op[i], p_imm[i]});
    chk("load_end_state", s_state, 0);
    chk("load_done", s_done, !stopped);
    chk("ready_idle", s_ldr, 0);
  endtask

  task automatic run_until_halt(input int exp_n, input int exp_pc);
    run_req = 1'b1; cyc(); run_req = 1'b0; cyc();
    chk("start_state", s_state, 2);
    chk("start_restart", s_rst, 1);
    chk("start_en", s_en, 0);
    en_cnt = 0; rst_cnt = 0;
    for (int k = 0; k < 80; k++) begin
      cyc();
      if (s_halted) break;
    end
    chk("halted", s_halted, 1);
    chk("run_en_cycles", en_cnt, exp_n);
    chk("halt_pc", s_pc, exp_pc);
    chk("halt_en", s_en, 0);
    chk("run_no_restart", rst_cnt, 0);
  endtask

  initial begin
    int h, n, hp, found, hcnt;
    logic [3:0] cur, exp_pc;
    rst_n = 1'b0; load_req = 1'b1; run_req = 1'b0; step_req = 1'b0; stop_req = 1'b0;
    ld_valid = 1'b1; ld_opcode = 4'h3; ld_imm = 4'h5; bp_addr = 4'd0; bp_en = 1'b0;
    @(negedge clk);
    cyc();
    chk("rst_state", s_state, 0);
    chk("rst_ready", s_ldr, 0);
    chk("rst_write", s_wr, 0);
    chk("rst_en", s_en, 0);
    chk("rst_restart", s_rst, 0);
    chk("rst_done", s_done, 0);
    chk("rst_halted", s_halted, 0);
    chk("rst_mem_addr", s_addr, 9);
    load_req = 1'b0; ld_valid = 1'b0; rst_n = 1'b1;
    cyc();

    // Full streaming load: op=i, imm=~i.
    for (int i = 0; i < 16; i++) begin p_op[i] = 4'(i); p_imm[i] = ~4'(i); end
    load_prog(1'b0, 16);

    // Priority: stop beats load/run; load beats run.
    stop_req = 1'b1; load_req = 1'b1; run_req = 1'b1; cyc();
    stop_req = 1'b0; load_req = 1'b0; run_req = 1'b0; cyc();
    chk("prio_stop", s_state, 0);
    load_req = 1'b1; run_req = 1'b1; cyc();
    load_req = 1'b0; run_req = 1'b0; cyc();
    chk("prio_load", s_state, 1);
    chk("load_done_clear", s_done, 0);
    stop_req = 1'b1; ld_valid = 1'b1; cyc();
    chk("stop_w0_no_write", s_wr, 0);
    stop_req = 1'b0; ld_valid = 1'b0; cyc();
    chk("stop_w0_state", s_state, 0);

    // Reset in the middle of a load abandons it.
    load_req = 1'b1; cyc(); load_req = 1'b0;
    ld_valid = 1'b1; cyc(); cyc(); cyc();
    rst_n = 1'b0; ld_valid = 1'b0; cyc();
    rst_n = 1'b1; cyc();
    chk("midrst_state", s_state, 0);
    chk("midrst_ready", s_ldr, 0);
    chk("midrst_done", s_done, 0);

    // Aborted load at word 5, starting again from address 0.
    for (int i = 0; i < 16; i++) begin p_op[i] = 4'($urandom); p_imm[i] = 4'($urandom); end
    load_prog(1'b0, 5);

    // Random programs ending in a jump-to-self; later loads start from HALT.
    for (int it = 0; it < 3; it++) begin
      h = $urandom_range(2, 15);
      for (int i = 0; i < 16; i++) begin
        p_op[i]  = 4'($urandom_range(0, 14));
        p_imm[i] = 4'($urandom);
        if (i < h && $urandom_range(0, 3) == 0) begin
          p_op[i]  = 4'hF;
          p_imm[i] = 4'($urandom_range(i + 1, h));
        end
      end
      p_op[h] = 4'hF; p_imm[h] = 4'(h);
      load_prog(1'b1, 16);
      trace(n, hp);
      run_until_halt(n, hp);
    end

    // Directed: F/7 at address 7 halts after eight instructions.
    for (int i = 0; i < 16; i++) begin p_op[i] = 4'h0; p_imm[i] = 4'($urandom); end
    p_op[7] = 4'hF; p_imm[7] = 4'd7;
    load_prog(1'b1, 16);
    run_until_halt(8, 7);

    // Directed: F/3 at address 7 loops forever without halting.
    p_imm[7] = 4'd3;
    load_prog(1'b0, 16);
    run_req = 1'b1; cyc(); run_req = 1'b0; cyc();
    en_cnt = 0; hcnt = 0;
    for (int k = 0; k < 40; k++) begin cyc(); if (s_halted) hcnt++; end
    chk("loop_en_cycles", en_cnt, 40);
    chk("loop_no_halt", hcnt, 0);
    stop_req = 1'b1; cyc();
    chk("stop_en_same_cycle", s_en, 1);
    stop_req = 1'b0; cyc();
    chk("stop_halted", s_halted, 1);
    chk("stop_en_dropped", s_en, 0);

    // Single step from HALT.
    cur = s_pc;
    exp_pc = (p_op[cur] == 4'hF) ? p_imm[cur] : cur + 4'd1;
    step_req = 1'b1; cyc(); step_req = 1'b0; cyc();
    chk("step_state", s_state, 5);
    chk("step_en", s_en, 1);
    cyc();
    chk("step_back_halt", s_state, 4);
    chk("step_en_off", s_en, 0);
    chk("step_pc", s_pc, exp_pc);

    // Held step_req: one step per HALT visit.
    en_cnt = 0; step_req = 1'b1;
    repeat (6) cyc();
    step_req = 1'b0; cyc();
    chk("held_step_count", en_cnt, 3);
    chk("held_step_halt", s_state, 4);

    // Resume from HALT: no restart.
    run_req = 1'b1; cyc(); run_req = 1'b0;
    en_cnt = 0; rst_cnt = 0;
    repeat (10) cyc();
    chk("resume_en", en_cnt, 10);
    chk("resume_no_restart", rst_cnt, 0);
    stop_req = 1'b1; cyc(); stop_req = 1'b0; cyc();
    chk("resume_stop_halt", s_halted, 1);

    // Breakpoint at address 4 on a straight-line program.
    for (int i = 0; i < 16; i++) begin p_op[i] = 4'h0; p_imm[i] = 4'($urandom); end
    load_prog(1'b0, 16);
    bp_en = 1'b1; bp_addr = 4'd4;
    run_req = 1'b1; cyc(); run_req = 1'b0; cyc();
    found = 0;
    for (int k = 0; k < 30; k++) begin
      cyc();
      if (s_state == 3'd3 && s_pc == 4'd4) begin found = 1; break; end
    end
    chk("bp_reached", found, 1);
    chk("bp_en_at_addr", s_en, !BP_ON);
    cyc();
    chk("bp_halted", s_halted, BP_ON);
    chk("bp_pc", s_pc, BP_ON ? 4 : 5);
    if (!s_halted) begin
      stop_req = 1'b1; cyc(); stop_req = 1'b0; cyc();
    end
    bp_addr = s_pc;
    run_req = 1'b1; cyc(); run_req = 1'b0; cyc();
    chk("bp_resume_state", s_state, 3);
    chk("bp_resume_en", s_en, 1);
    stop_req = 1'b1; cyc(); stop_req = 1'b0; bp_en = 1'b0; cyc();
    chk("final_halt", s_halted, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
